// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks in-flight register writes from E to WB and
// derives stall/flush/forward controls for the decode-stage instruction.
module hazard_scoreboard #(
  parameter int RADDR_W    = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int NUM_SRC    = 3,
  parameter int FWD_EN     = 0,
  parameter int RF_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      issue_valid,
  input  logic                                      issue_we,
  input  logic [RADDR_W-1:0]                        issue_rd,
  input  logic                                      issue_load,
  input  logic [NUM_SRC-1:0]                        rs_valid,
  input  logic [NUM_SRC*RADDR_W-1:0]                rs_addr,
  input  logic                                      redirect,
  output logic                                      stall_F,
  output logic                                      stall_D,
  output logic                                      flush_D,
  output logic                                      flush_E,
  output logic [NUM_SRC*$clog2(PIPE_DEPTH+1)-1:0]   fwd_sel,
  output logic [2**RADDR_W-1:0]                     pending,
  output logic [CNT_W-1:0]                          stall_cnt
);

  localparam int SEL_W    = $clog2(PIPE_DEPTH+1);
  // With a write-first register file the WB entry is already visible to D.
  localparam int CHK_LAST = (RF_BYPASS != 0) ? PIPE_DEPTH-2 : PIPE_DEPTH-1;

  if (PIPE_DEPTH < 2 || PIPE_DEPTH > 8) begin : g_bad_depth
    $error("hazard_scoreboard: PIPE_DEPTH must be in 2..8");
  end

  // Entry 0 is the instruction in E; entry PIPE_DEPTH-1 is in WB.
  logic [PIPE_DEPTH-1:0]              ent_v;
  logic [PIPE_DEPTH-1:0]              ent_ld;
  logic [PIPE_DEPTH-1:0][RADDR_W-1:0] ent_rd;

  logic [NUM_SRC-1:0][PIPE_DEPTH-1:0] src_match;
  logic                               hazard_any;
  logic                               hazard;
  logic                               accept;

  always_comb begin : match_logic
    src_match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        src_match[i][k] = rs_valid[i]
                          && (rs_addr[i*RADDR_W +: RADDR_W] != '0)
                          && ent_v[k]
                          && (ent_rd[k] == rs_addr[i*RADDR_W +: RADDR_W]);
      end
    end
  end

  always_comb begin : hazard_logic
    hazard_any = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (FWD_EN == 0) begin
        for (int k = 0; k < PIPE_DEPTH; k++) begin
          if (k <= CHK_LAST && src_match[i][k]) hazard_any = 1'b1;
        end
      end else begin
        // Only a load in E cannot be forwarded in time.
        if (src_match[i][0] && ent_ld[0]) hazard_any = 1'b1;
      end
    end
    hazard = issue_valid & hazard_any;
  end

  always_comb begin : fwd_logic
    fwd_sel = '0;
    if (FWD_EN != 0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        // Scan oldest to youngest so the youngest match is written last.
        for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
          if (src_match[i][k]) begin
            fwd_sel[i*SEL_W +: SEL_W] = (k == 0 && ent_ld[0]) ? '0 : SEL_W'(k+1);
          end
        end
      end
    end
  end

  always_comb begin : pending_logic
    pending = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (ent_v[k]) pending[ent_rd[k]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  // Issue handshake: D offers an instruction with issue_valid; it is taken into
  // E on a clock edge only when issue_valid=1, hazard=0 and redirect=0.
  // stall_D is the backpressure, redirect discards the D instruction instead.
  assign accept  = issue_valid & ~hazard & ~redirect;
  assign stall_F = hazard & ~redirect;
  assign stall_D = hazard & ~redirect;
  assign flush_E = hazard | redirect;
  assign flush_D = redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_v  <= '0;
      ent_ld <= '0;
      ent_rd <= '0;
    end else begin
      ent_v  <= {ent_v[PIPE_DEPTH-2:0],  accept & issue_we & (issue_rd != '0)};
      ent_ld <= {ent_ld[PIPE_DEPTH-2:0], accept & issue_load};
      ent_rd <= {ent_rd[PIPE_DEPTH-2:0], accept ? issue_rd : {RADDR_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_D && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four instances (default, forwarding,
// narrow counter, no RF bypass) share one stimulus stream.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        issue_valid, issue_we, issue_load, redirect;
  logic [4:0]  issue_rd;
  logic [2:0]  rs_valid;
  logic [14:0] rs_addr;

  int checks = 0;
  int errors = 0;

  logic d_sf, d_sd, d_fd, d_fe; logic [5:0] d_fwd; logic [31:0] d_pend; logic [15:0] d_cnt;
  logic f_sf, f_sd, f_fd, f_fe; logic [5:0] f_fwd; logic [31:0] f_pend; logic [15:0] f_cnt;
  logic c_sf, c_sd, c_fd, c_fe; logic [5:0] c_fwd; logic [31:0] c_pend; logic [1:0]  c_cnt;
  logic n_sf, n_sd, n_fd, n_fe; logic [5:0] n_fwd; logic [31:0] n_pend; logic [15:0] n_cnt;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_load(issue_load), .rs_valid(rs_valid), .rs_addr(rs_addr),
    .redirect(redirect), .stall_F(d_sf), .stall_D(d_sd), .flush_D(d_fd), .flush_E(d_fe),
    .fwd_sel(d_fwd), .pending(d_pend), .stall_cnt(d_cnt));

  hazard_scoreboard #(.FWD_EN(1)) dut_fwd (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_load(issue_load), .rs_valid(rs_valid), .rs_addr(rs_addr),
    .redirect(redirect), .stall_F(f_sf), .stall_D(f_sd), .flush_D(f_fd), .flush_E(f_fe),
    .fwd_sel(f_fwd), .pending(f_pend), .stall_cnt(f_cnt));

  hazard_scoreboard #(.CNT_W(2)) dut_cnt (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_load(issue_load), .rs_valid(rs_valid), .rs_addr(rs_addr),
    .redirect(redirect), .stall_F(c_sf), .stall_D(c_sd), .flush_D(c_fd), .flush_E(c_fe),
    .fwd_sel(c_fwd), .pending(c_pend), .stall_cnt(c_cnt));

  hazard_scoreboard #(.RF_BYPASS(0)) dut_nobyp (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_load(issue_load), .rs_valid(rs_valid), .rs_addr(rs_addr),
    .redirect(redirect), .stall_F(n_sf), .stall_D(n_sd), .flush_D(n_fd), .flush_E(n_fe),
    .fwd_sel(n_fwd), .pending(n_pend), .stall_cnt(n_cnt));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Driver
  task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic ld,
                       input logic [2:0] rsv, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic redir);
    issue_valid = v;
    issue_we    = we;
    issue_rd    = rd;
    issue_load  = ld;
    rs_valid    = rsv;
    rs_addr     = {a3, a2, a1};
    redirect    = redir;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    #2;
    chk("rst_stall_D", d_sd, 0);
    chk("rst_flush_E", d_fe, 0);
    chk("rst_pending", d_pend, 0);
    chk("rst_cnt", d_cnt, 0);
    tick();
    reset = 1'b0;

    // RAW on x5 without forwarding; forwarding instance must not stall
    drive(1, 1, 5, 0, 3'b000, 0, 0, 0, 0);
    #1; chk("raw_a_stall", d_sd, 0);
    tick();
    drive(1, 1, 6, 0, 3'b011, 5, 1, 0, 0);
    #1;
    chk("raw_b_stall_D", d_sd, 1);
    chk("raw_b_stall_F", d_sf, 1);
    chk("raw_b_flush_E", d_fe, 1);
    chk("raw_b_flush_D", d_fd, 0);
    chk("raw_b_pending", d_pend, 32'h20);
    chk("raw_b_fwd_off", d_fwd, 0);
    chk("fwd_b_stall", f_sd, 0);
    chk("fwd_b_sel", f_fwd, 6'b000001);
    tick();
    #1;
    chk("raw_c_stall_D", d_sd, 1);
    chk("raw_c_pending", d_pend, 32'h20);
    chk("fwd_c_sel", f_fwd, 6'b000010);
    tick();
    #1;
    chk("raw_d_stall_D", d_sd, 0);
    chk("raw_d_flush_E", d_fe, 0);
    chk("raw_d_pending", d_pend, 32'h20);
    chk("raw_d_cnt", d_cnt, 2);
    chk("fwd_d_sel", f_fwd, 6'b000011);
    chk("nobyp_d_stall", n_sd, 1);
    tick();
    #1;
    chk("raw_e_pending", d_pend, 32'h40);
    chk("nobyp_e_stall", n_sd, 0);
    chk("nobyp_e_cnt", n_cnt, 3);

    // Load-use on x7 with forwarding
    do_reset();
    drive(1, 1, 7, 1, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    drive(1, 1, 8, 0, 3'b010, 0, 7, 0, 0);
    #1;
    chk("ld_b_stall", f_sd, 1);
    chk("ld_b_flush_E", f_fe, 1);
    chk("ld_b_sel", f_fwd, 0);
    tick();
    #1;
    chk("ld_c_stall", f_sd, 0);
    chk("ld_c_sel", f_fwd, 6'b001000);
    chk("ld_c_cnt", f_cnt, 1);

    // Redirect beats hazard
    do_reset();
    drive(1, 1, 5, 0, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    drive(1, 1, 6, 0, 3'b001, 5, 0, 0, 1);
    #1;
    chk("redir_stall_D", d_sd, 0);
    chk("redir_stall_F", d_sf, 0);
    chk("redir_flush_D", d_fd, 1);
    chk("redir_flush_E", d_fe, 1);
    tick();
    drive(1, 1, 9, 0, 3'b000, 0, 0, 0, 1);
    #1;
    chk("redir2_pending", d_pend, 32'h20);
    chk("redir2_cnt", d_cnt, 0);
    chk("redir2_flush_E", d_fe, 1);
    chk("redir2_stall_D", d_sd, 0);
    tick();
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    chk("redir3_pending", d_pend, 32'h20);
    chk("redir3_cnt", d_cnt, 0);

    // x0 is never tracked; youngest duplicate wins forwarding
    do_reset();
    drive(1, 1, 0, 0, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    drive(1, 0, 0, 0, 3'b001, 0, 0, 0, 0);
    #1;
    chk("x0_stall", d_sd, 0);
    chk("x0_pending", d_pend, 0);
    chk("x0_fwd", f_fwd, 0);
    tick();
    drive(1, 1, 3, 0, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    #1;
    tick();
    drive(1, 0, 0, 0, 3'b101, 3, 0, 3, 0);
    #1;
    chk("young_fwd", f_fwd, 6'b010001);
    chk("young_stall", f_sd, 0);
    chk("dup_pending", d_pend, 32'h8);
    chk("dup_stall_nofwd", d_sd, 1);

    // Saturating 2-bit counter, then reset mid-stall
    do_reset();
    drive(1, 1, 1, 0, 3'b000, 0, 0, 0, 0);
    #1;
    tick();
    drive(1, 1, 2, 0, 3'b001, 1, 0, 0, 0);
    #1; chk("sat_b_stall", c_sd, 1);
    tick();
    #1; chk("sat_c_stall", c_sd, 1);
    tick();
    #1; chk("sat_d_cnt", c_cnt, 2);
    tick();
    drive(1, 1, 3, 0, 3'b001, 2, 0, 0, 0);
    #1; chk("sat_e_stall", c_sd, 1);
    tick();
    #1;
    chk("sat_f_stall", c_sd, 1);
    chk("sat_f_cnt", c_cnt, 3);
    tick();
    #1; chk("sat_g_cnt", c_cnt, 3);
    tick();
    drive(1, 1, 4, 0, 3'b001, 3, 0, 0, 0);
    #1; chk("sat_h_stall", c_sd, 1);
    tick();
    #1;
    chk("sat_i_stall", c_sd, 1);
    chk("sat_i_cnt", c_cnt, 3);
    reset = 1'b1;
    #1;
    chk("midrst_stall_D", c_sd, 0);
    chk("midrst_stall_F", c_sf, 0);
    chk("midrst_flush_E", c_fe, 0);
    chk("midrst_cnt", c_cnt, 0);
    chk("midrst_pending", c_pend, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the core's `hazard_logic` block.
- Tracks in-flight register writes in a shift-register scoreboard, one entry per stage from E to WB. Depth is parametrised.
- Compares up to NUM_SRC decode-stage source operands against pending writes, then generates stall, bubble and flush controls for the F/D/E pipeline.
- In forwarding mode it emits per-source forward selects and stalls only on load-use. It also counts stall cycles for performance analysis.

Parameters:
- RADDR_W, 5, register-address width; register 0 is hardwired zero.
- PIPE_DEPTH, 3, number of tracked stages after D (entry 0 = E, entry PIPE_DEPTH-1 = WB); legal range 2..8.
- NUM_SRC, 3, number of source operands checked (rs1, rs2, rs3).
- FWD_EN, 0, 0 = stall on any RAW match; 1 = forwarding available, stall only on load-use.
- RF_BYPASS, 1, 1 = register file is write-first, so a match in the WB entry is not a hazard.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- issue_valid  in  1  D stage holds a valid instruction
- issue_we  in  1  D-stage instruction writes a register
- issue_rd  in  RADDR_W  D-stage destination register
- issue_load  in  1  D-stage instruction is a load
- rs_valid  in  NUM_SRC  per-source "operand is read" flags
- rs_addr  in  NUM_SRC*RADDR_W  packed source addresses; source i occupies bits [i*RADDR_W +: RADDR_W]
- redirect  in  1  taken branch/jump resolved in E
- stall_F  out  1  hold PC
- stall_D  out  1  hold F/D register
- flush_D  out  1  clear F/D register
- flush_E  out  1  clear D/E register (insert bubble)
- fwd_sel  out  NUM_SRC*$clog2(PIPE_DEPTH+1)  per source: 0 = register file, k = forward from entry k-1
- pending  out  2**RADDR_W  bitmask of registers with a valid in-flight write; bit 0 always 0
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- State:
  - entry[k] = {v, rd, ld} for k = 0..PIPE_DEPTH-1.
  - stall_cnt.
- Reset (asynchronous): all entry v=0, rd=0, ld=0; stall_cnt=0. Consequently every output is 0 while in reset and immediately after.
- Match rule: source i matches entry k when rs_valid[i], rs_addr_i != 0, entry[k].v, and entry[k].rd == rs_addr_i.
- hazard, when FWD_EN=0: issue_valid and some source matches some entry k, where:
  - k ranges over 0..PIPE_DEPTH-2 when RF_BYPASS=1;
  - k ranges over 0..PIPE_DEPTH-1 when RF_BYPASS=0.
- hazard, when FWD_EN=1: issue_valid and some source matches entry 0 with entry[0].ld=1 (load-use).
- fwd_sel[i]:
  - Forced to 0 when FWD_EN=0.
  - Otherwise k+1 for the lowest-index (youngest) matching entry k; 0 if no match or the matching entry is a load in entry 0.
  - Youngest-match priority is required when the same rd appears in several entries.
- Combinational outputs, same cycle as the inputs:
  - stall_F = stall_D = hazard & ~redirect
  - flush_E = hazard | redirect
  - flush_D = redirect
  - Redirect beats hazard: the wrong-path D instruction is discarded, not stalled.
- Sequential update on each rising clk when not in reset:
  - entry[k+1] <= entry[k] for k = 0..PIPE_DEPTH-2; entry PIPE_DEPTH-1 retires.
  - entry[0] <= bubble (v=0) if hazard, redirect, or !issue_valid.
  - Otherwise entry[0] <= {issue_we & (issue_rd != 0), issue_rd, issue_load}.
- Redirect does not invalidate existing entries: the E instruction and older instructions are architecturally committed.
- stall_cnt increments by 1 on every cycle where stall_D=1; it holds at 2**CNT_W-1 (saturates, no wrap).
- pending is the OR over valid entries of the one-hot of rd. Duplicate rd in several entries still yields a single bit.
- Writes to x0 are never tracked, and reads of x0 never match.
- A hazard clears itself: the producer advances while the consumer holds in D. Worst-case stall, when FWD_EN=0 and the producer is in entry 0:
  - PIPE_DEPTH-1 cycles when RF_BYPASS=1;
  - PIPE_DEPTH cycles when RF_BYPASS=0.
- Reset asserted mid-stall: state clears asynchronously; stall outputs drop in the same cycle.

Test Plan:
- Defaults (FWD_EN=0, PIPE_DEPTH=3, RF_BYPASS=1): issue `addi x5` (we=1, rd=5), next cycle issue `add x6,x5,x1` with rs_valid=3'b011 -> stall_D=stall_F=flush_E=1 for exactly 2 cycles, deasserted on the 3rd; stall_cnt=2; pending[5]=1 for 3 cycles after issue.
- Same sequence with FWD_EN=1 and issue_load=0 -> no stall; fwd_sel for rs1 = 1 in the consumer's first D cycle.
- FWD_EN=1, issue `lw x7`, then a consumer with rs2=x7 -> exactly 1 stall cycle, then fwd_sel for rs2 = 2; stall_cnt=1.
- Hazard present and redirect=1 in the same cycle -> stall_D=0, flush_D=1, flush_E=1; next cycle entry 0 is a bubble; stall_cnt unchanged.
- rd=x0 write followed by an rs1=x0 read -> no stall, pending=0, fwd_sel=0; with x3 in entries 0 and 1 and FWD_EN=1, fwd_sel selects 1 (youngest).
- CNT_W=2, hold a persistent RAW hazard for 5 stall cycles -> stall_cnt stops at 3; assert reset mid-stall -> all outputs 0 before the next clock edge.
